fpu_issue_ctrl: RTL and testbench



---
 rtl/fpu_issue_ctrl_if.sv | 27 ++
 rtl/fpu_issue_ctrl.sv | 158 +++++++++++++++
 tb/tb_fpu_issue_ctrl.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fpu_issue_ctrl_if.sv
// Request/result bundle between the CPU execute stage and fpu_issue_ctrl.
// master = CPU side (issues ops, receives results); slave = controller side.
interface fpu_issue_ctrl_if #(
  parameter int unsigned NUM_UNITS = 8,
  parameter int unsigned DATA_W    = 32
);
  logic                 in_valid;
  logic                 in_ready;
  logic [NUM_UNITS-1:0] in_op;
  logic [DATA_W-1:0]    in_x1;
  logic [DATA_W-1:0]    in_x2;
  logic [DATA_W-1:0]    y;
  logic                 out_valid;
  logic                 ovf;
  logic                 unf;
  logic                 illegal;

  modport master (
    output in_valid, in_op, in_x1, in_x2,
    input  in_ready, y, out_valid, ovf, unf, illegal
  );

  modport slave (
    input  in_valid, in_op, in_x1, in_x2,
    output in_ready, y, out_valid, ovf, unf, illegal
  );
endinterface

// File: rtl/fpu_issue_ctrl.sv
// Issue/completion controller for the FPU cluster: in-order, single-unit bursts of up to
// MAX_INFLIGHT ops. Define FPU_EXC_STICKY_EN to build the sticky ovf/unf accumulators.
module fpu_issue_ctrl #(
  parameter int unsigned NUM_UNITS    = 8,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned MAX_INFLIGHT = 4
) (
  input  logic                          sys_clk,
  input  logic                          rst,
  fpu_issue_ctrl_if.slave               req,
  output logic [NUM_UNITS-1:0]          unit_start,
  output logic [DATA_W-1:0]             unit_x1,
  output logic [DATA_W-1:0]             unit_x2,
  input  logic [NUM_UNITS*DATA_W-1:0]   unit_y,
  input  logic [NUM_UNITS-1:0]          unit_valid,
  input  logic [NUM_UNITS-1:0]          unit_ovf,
  input  logic [NUM_UNITS-1:0]          unit_unf,
  output logic                          busy,
  input  logic                          flag_clr,
  output logic                          sticky_ovf,
  output logic                          sticky_unf
);

  localparam int unsigned CntW = $clog2(MAX_INFLIGHT + 1);
  localparam logic [CntW-1:0] MaxCnt = CntW'(MAX_INFLIGHT);

  typedef enum logic [1:0] {StIdle, StRun, StErr} state_e;

  state_e               r_state, w_state_d;
  logic [CntW-1:0]      r_cnt, w_cnt_d;
  logic [NUM_UNITS-1:0] r_cur;
  logic [NUM_UNITS-1:0] r_start;
  logic [DATA_W-1:0]    r_x1, r_x2, r_y;
  logic                 r_out_valid, r_ovf, r_unf, r_illegal;

  logic                 w_ready, w_onehot, w_acc, w_acc_legal, w_acc_illegal, w_cmp;
  logic [DATA_W-1:0]    w_y_sel;
  logic                 w_ovf_sel, w_unf_sel;

  assign w_onehot = $onehot(req.in_op);

  // Only the unit already in flight may be issued again, which keeps results in order.
  assign w_ready = !rst && ((r_state == StIdle) ||
                            (r_state == StRun && r_cnt < MaxCnt && req.in_op == r_cur));

  assign w_acc         = req.in_valid && w_ready;
  assign w_acc_legal   = w_acc && w_onehot;
  assign w_acc_illegal = w_acc && !w_onehot;
  assign w_cmp         = (r_state == StRun) && (r_cnt != '0) && ((unit_valid & r_cur) != '0);

  always_comb begin
    w_y_sel   = '0;
    w_ovf_sel = |(unit_ovf & r_cur);
    w_unf_sel = |(unit_unf & r_cur);
    for (int k = 0; k < int'(NUM_UNITS); k++) begin
      if (r_cur[k]) w_y_sel = w_y_sel | unit_y[k*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    w_cnt_d = r_cnt;
    if (w_acc_legal && !w_cmp) begin
      w_cnt_d = r_cnt + 1'b1;
    end else if (!w_acc_legal && w_cmp) begin
      w_cnt_d = r_cnt - 1'b1;
    end
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle: begin
        if (w_acc_legal) begin
          w_state_d = StRun;
        end else if (w_acc_illegal) begin
          w_state_d = StErr;
        end
      end
      StRun:   if (w_cnt_d == '0) w_state_d = StIdle;
      StErr:   w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      r_state     <= StIdle;
      r_cnt       <= '0;
      r_cur       <= '0;
      r_start     <= '0;
      r_x1        <= '0;
      r_x2        <= '0;
      r_y         <= '0;
      r_out_valid <= 1'b0;
      r_ovf       <= 1'b0;
      r_unf       <= 1'b0;
      r_illegal   <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
      if (w_acc_legal) begin
        r_cur <= req.in_op;
        r_x1  <= req.in_x1;
        r_x2  <= req.in_x2;
      end
      r_start     <= w_acc_legal ? req.in_op : '0;
      // An illegal op reports through the same result port as a zero result.
      r_out_valid <= w_cmp || w_acc_illegal;
      r_y         <= w_cmp ? w_y_sel : '0;
      r_ovf       <= w_cmp && w_ovf_sel;
      r_unf       <= w_cmp && w_unf_sel;
      r_illegal   <= w_acc_illegal;
    end
  end

  assign req.in_ready  = w_ready;
  assign req.y         = r_y;
  assign req.out_valid = r_out_valid;
  assign req.ovf       = r_ovf;
  assign req.unf       = r_unf;
  assign req.illegal   = r_illegal;
  assign unit_start    = r_start;
  assign unit_x1       = r_x1;
  assign unit_x2       = r_x2;
  assign busy          = (r_state != StIdle);

`ifdef FPU_EXC_STICKY_EN
  logic r_sticky_ovf, r_sticky_unf;

  // Set has priority over clear so an exception in the clearing cycle is not lost.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      r_sticky_ovf <= 1'b0;
      r_sticky_unf <= 1'b0;
    end else begin
      if (r_out_valid && r_ovf) begin
        r_sticky_ovf <= 1'b1;
      end else if (flag_clr) begin
        r_sticky_ovf <= 1'b0;
      end
      if (r_out_valid && r_unf) begin
        r_sticky_unf <= 1'b1;
      end else if (flag_clr) begin
        r_sticky_unf <= 1'b0;
      end
    end
  end

  assign sticky_ovf = r_sticky_ovf;
  assign sticky_unf = r_sticky_unf;
`else
  logic w_unused_flag_clr;
  assign w_unused_flag_clr = flag_clr;
  assign sticky_ovf        = 1'b0;
  assign sticky_unf        = 1'b0;
`endif

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Directed bench for fpu_issue_ctrl with behavioural pipelined unit models
// (fadd lat 4, fsub lat 2, fmul lat 3).
module tb_fpu_issue_ctrl;

  localparam int unsigned NU = 8;
  localparam int unsigned DW = 32;
  localparam int LAT [8] = '{4, 2, 3, 1, 1, 1, 1, 1};

`ifdef FPU_EXC_STICKY_EN
  localparam logic StickyEn = 1'b1;
`else
  localparam logic StickyEn = 1'b0;
`endif

  // Per-cycle expectations: bit c refers to cycle c of the respective sequence.
  localparam logic [7:0]  BurstRdy = 8'b1100_1111;
  localparam logic [14:0] BurstOv  = 15'b011_0011_1100_0000;
  localparam logic [6:0]  SwRdy    = 7'b100_0001;
  localparam logic [11:0] SwOv     = 12'b0100_0100_0000;

  logic                sys_clk;
  logic                rst;
  logic [NU-1:0]       unit_start;
  logic [DW-1:0]       unit_x1, unit_x2;
  logic [NU*DW-1:0]    unit_y;
  logic [NU-1:0]       unit_valid, unit_ovf, unit_unf;
  logic                busy, flag_clr, sticky_ovf, sticky_unf;

  logic [NU-1:0]       tb_ovf, tb_unf, tb_extra_valid;
  logic [7:0]          pv [8];
  logic [7:0]          po [8];
  logic [7:0]          pu [8];
  logic [DW-1:0]       pd [8][8];

  int                  n_checks, n_pass, n_out, next_op;
  logic                acc;

  fpu_issue_ctrl_if #(.NUM_UNITS(NU), .DATA_W(DW)) bus ();

  fpu_issue_ctrl #(
    .NUM_UNITS   (NU),
    .DATA_W      (DW),
    .MAX_INFLIGHT(4)
  ) dut (
    .sys_clk   (sys_clk),
    .rst       (rst),
    .req       (bus),
    .unit_start(unit_start),
    .unit_x1   (unit_x1),
    .unit_x2   (unit_x2),
    .unit_y    (unit_y),
    .unit_valid(unit_valid),
    .unit_ovf  (unit_ovf),
    .unit_unf  (unit_unf),
    .busy      (busy),
    .flag_clr  (flag_clr),
    .sticky_ovf(sticky_ovf),
    .sticky_unf(sticky_unf)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  function automatic logic [DW-1:0] unit_fn(input int k, input logic [DW-1:0] a,
                                            input logic [DW-1:0] b);
    case (k)
      0:       return a + b;
      1:       return a - b;
      2:       return (a == 32'h4000_0000 && b == 32'h4040_0000) ? 32'h40C0_0000 : a * b;
      default: return a;
    endcase
  endfunction

  always @(posedge sys_clk) begin
    for (int k = 0; k < 8; k++) begin
      for (int j = 7; j > 0; j--) begin
        pv[k][j] <= pv[k][j-1];
        po[k][j] <= po[k][j-1];
        pu[k][j] <= pu[k][j-1];
        pd[k][j] <= pd[k][j-1];
      end
      pv[k][0] <= unit_start[k];
      po[k][0] <= tb_ovf[k];
      pu[k][0] <= tb_unf[k];
      pd[k][0] <= unit_fn(k, unit_x1, unit_x2);
    end
  end

  always_comb begin
    unit_valid = '0;
    unit_ovf   = '0;
    unit_unf   = '0;
    unit_y     = '0;
    for (int k = 0; k < 8; k++) begin
      unit_valid[k]          = pv[k][LAT[k]-1] | tb_extra_valid[k];
      unit_ovf[k]            = po[k][LAT[k]-1];
      unit_unf[k]            = pu[k][LAT[k]-1];
      unit_y[k*DW +: DW]     = pd[k][LAT[k]-1];
    end
  end

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic issue1(input logic [NU-1:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    bus.in_valid = 1'b1;
    bus.in_op    = op;
    bus.in_x1    = a;
    bus.in_x2    = b;
    #1;
    chk("issue_ready", bus.in_ready, 1);
    tick();
    bus.in_valid = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    n_out    = 0;
    rst      = 1'b1;
    flag_clr = 1'b0;
    tb_ovf   = '0;
    tb_unf   = '0;
    tb_extra_valid = '0;
    bus.in_valid = 1'b0;
    bus.in_op    = '0;
    bus.in_x1    = '0;
    bus.in_x2    = '0;
    repeat (10) tick();

    // Reset state; in_ready must stay low even with a legal request pending.
    bus.in_valid = 1'b1;
    bus.in_op    = 8'h04;
    #1;
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_unit_start", unit_start, 0);
    chk("rst_unit_x1", unit_x1, 0);
    chk("rst_y", bus.y, 0);
    chk("rst_illegal", bus.illegal, 0);
    chk("rst_sticky_ovf", sticky_ovf, 0);
    bus.in_valid = 1'b0;
    rst = 1'b0;
    tick();
    chk("idle_in_ready", bus.in_ready, 1);

    // Single fmul, result at accept+5.
    issue1(8'h04, 32'h4000_0000, 32'h4040_0000);
    chk("fmul_start", unit_start, 32'h04);
    chk("fmul_x1", unit_x1, 32'h4000_0000);
    chk("fmul_x2", unit_x2, 32'h4040_0000);
    chk("fmul_busy", busy, 1);
    tick();
    chk("fmul_start_pulse", unit_start, 0);
    chk("fmul_ov_a2", bus.out_valid, 0);
    tick();
    chk("fmul_ov_a3", bus.out_valid, 0);
    tick();
    chk("fmul_ov_a4", bus.out_valid, 0);
    tick();
    chk("fmul_ov", bus.out_valid, 1);
    chk("fmul_y", bus.y, 32'h40C0_0000);
    chk("fmul_ovf", bus.ovf, 0);
    chk("fmul_unf", bus.unf, 0);
    chk("fmul_illegal", bus.illegal, 0);
    chk("fmul_busy_drop", busy, 0);
    chk("fmul_x1_hold", unit_x1, 32'h4000_0000);
    tick();
    chk("fmul_ov_pulse", bus.out_valid, 0);

    // Burst of 6 fadd ops with x1=1..6, x2=100.
    next_op = 1;
    n_out   = 0;
    for (int c = 0; c < 15; c++) begin
      chk("burst_out_valid", bus.out_valid, BurstOv[c]);
      if (BurstOv[c]) begin
        chk("burst_y", bus.y, 32'd101 + n_out);
        n_out++;
      end
      bus.in_valid = (next_op <= 6);
      bus.in_op    = 8'h01;
      bus.in_x1    = next_op;
      bus.in_x2    = 32'd100;
      #1;
      if (c < 8) chk("burst_ready", bus.in_ready, BurstRdy[c]);
      acc = bus.in_valid && bus.in_ready;
      tick();
      if (acc) next_op++;
    end
    bus.in_valid = 1'b0;
    chk("burst_count", n_out, 6);
    chk("burst_idle", busy, 0);

    // fadd then fsub: fsub waits for the fadd result.
    n_out = 0;
    acc   = 1'b0;
    for (int c = 0; c < 12; c++) begin
      chk("sw_out_valid", bus.out_valid, SwOv[c]);
      if (SwOv[c]) begin
        chk("sw_y", bus.y, (n_out == 0) ? 32'd15 : 32'd42);
        n_out++;
      end
      if (c == 1) chk("sw_start_fadd", unit_start, 32'h01);
      if (c == 7) chk("sw_start_fsub", unit_start, 32'h02);
      if (c == 0) begin
        bus.in_valid = 1'b1;
        bus.in_op    = 8'h01;
        bus.in_x1    = 32'd10;
        bus.in_x2    = 32'd5;
      end else begin
        bus.in_valid = !acc;
        bus.in_op    = 8'h02;
        bus.in_x1    = 32'd50;
        bus.in_x2    = 32'd8;
      end
      #1;
      if (c < 7) chk("sw_ready", bus.in_ready, SwRdy[c]);
      if (c > 0 && bus.in_valid && bus.in_ready) acc = 1'b1;
      tick();
    end
    bus.in_valid = 1'b0;

    // Illegal multi-hot opcode.
    bus.in_valid = 1'b1;
    bus.in_op    = 8'h03;
    #1;
    chk("ill_ready", bus.in_ready, 1);
    tick();
    bus.in_valid = 1'b0;
    chk("ill_no_start", unit_start, 0);
    chk("ill_out_valid", bus.out_valid, 1);
    chk("ill_flag", bus.illegal, 1);
    chk("ill_y", bus.y, 0);
    chk("ill_ovf", bus.ovf, 0);
    chk("ill_busy", busy, 1);
    tick();
    chk("ill_ov_pulse", bus.out_valid, 0);
    chk("ill_flag_pulse", bus.illegal, 0);
    chk("ill_idle", busy, 0);
    chk("ill_ready_after", bus.in_ready, 1);

    // Stray unit_valid while idle is ignored.
    tb_extra_valid = 8'hFF;
    tick();
    tb_extra_valid = '0;
    tick();
    chk("stray_out_valid", bus.out_valid, 0);

    // Reset with three fmul ops in flight; their late results must vanish.
    issue1(8'h04, 32'd1, 32'd3);
    issue1(8'h04, 32'd2, 32'd3);
    issue1(8'h04, 32'd3, 32'd3);
    chk("mid_start", unit_start, 32'h04);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("mid_busy", busy, 0);
    chk("mid_start_clr", unit_start, 0);
    chk("mid_ready", bus.in_ready, 1);
    for (int c = 0; c < 5; c++) begin
      chk("mid_no_out", bus.out_valid, 0);
      tick();
    end
    chk("mid_ready_after", bus.in_ready, 1);

    // Overflow result, sticky hold across a clean op, then clear.
    tb_ovf = 8'h04;
    issue1(8'h04, 32'd1, 32'd2);
    tick();
    tb_ovf = '0;
    repeat (3) tick();
    chk("ovf_out_valid", bus.out_valid, 1);
    chk("ovf_y", bus.y, 32'd2);
    chk("ovf_flag", bus.ovf, 1);
    chk("ovf_unf", bus.unf, 0);
    tick();
    chk("sticky_set", sticky_ovf, StickyEn);
    chk("sticky_unf_clear", sticky_unf, 0);
    issue1(8'h04, 32'd4, 32'd5);
    repeat (4) tick();
    chk("clean_out_valid", bus.out_valid, 1);
    chk("clean_ovf", bus.ovf, 0);
    tick();
    chk("sticky_hold", sticky_ovf, StickyEn);
    flag_clr = 1'b1;
    tick();
    flag_clr = 1'b0;
    chk("sticky_cleared", sticky_ovf, 0);

    // Set beats clear when both land in the same cycle.
    tb_ovf = 8'h04;
    issue1(8'h04, 32'd6, 32'd7);
    tick();
    tb_ovf = '0;
    repeat (3) tick();
    chk("race_ovf", bus.ovf, 1);
    flag_clr = 1'b1;
    tick();
    chk("race_set_wins", sticky_ovf, StickyEn);
    tick();
    flag_clr = 1'b0;
    chk("race_clear_next", sticky_ovf, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
